muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID-stage decoder. It consumes the decoder's `ALUOP_MUL`…`ALUOP_REMU` operation codes together with the two forwarded operands and produces a 32-bit result after a fixed, known latency. While it works it holds `busy_o` high so the pipeline stalls. A `kill_i` flush from a branch or interrupt aborts any in-flight operation.

---
 rtl/muldiv_unit_pkg.sv | 47 ++++
 rtl/muldiv_unit_div_iter.sv | 25 ++
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared operation codes, state encodings and helpers for the RV32M multiply/divide unit.
package muldiv_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned CNT_W  = 5;

  // Decoder operation codes seen by the EX stage
  localparam logic [OP_W-1:0] ALUOP_ADD    = 5'd0;
  localparam logic [OP_W-1:0] ALUOP_MUL    = 5'd16;
  localparam logic [OP_W-1:0] ALUOP_MULH   = 5'd17;
  localparam logic [OP_W-1:0] ALUOP_MULHSU = 5'd18;
  localparam logic [OP_W-1:0] ALUOP_MULHU  = 5'd19;
  localparam logic [OP_W-1:0] ALUOP_DIV    = 5'd20;
  localparam logic [OP_W-1:0] ALUOP_DIVU   = 5'd21;
  localparam logic [OP_W-1:0] ALUOP_REM    = 5'd22;
  localparam logic [OP_W-1:0] ALUOP_REMU   = 5'd23;

  typedef enum logic [2:0] {
    MDU_IDLE = 3'd0,
    MDU_MUL  = 3'd1,
    MDU_DIV  = 3'd2,
    MDU_FIX  = 3'd3,
    MDU_DONE = 3'd4
  } mdu_state_e;

  // Operation context captured on accept
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic            neg_quo;
    logic            neg_rem;
  } mdu_ctrl_t;

  function automatic logic is_m_op(input logic [OP_W-1:0] op);
    return (op >= ALUOP_MUL) && (op <= ALUOP_REMU);
  endfunction

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op >= ALUOP_MUL) && (op <= ALUOP_MULHU);
  endfunction

  function automatic logic [DATA_W-1:0] abs_w(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? DATA_W'(-x) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// One radix-2 restoring division step: shift in the next dividend bit, subtract if it fits.
module muldiv_unit_div_iter
  import muldiv_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] div_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;
  logic              fits;

  // Partial remainder can reach DATA_W+1 bits before the compare
  always_comb begin
    shifted = {rem_i, quo_i[DATA_W-1]};
    fits    = shifted[DATA_W] | (shifted[DATA_W-1:0] >= div_i);
    diff    = shifted[DATA_W-1:0] - div_i;
    rem_o   = fits ? diff : shifted[DATA_W-1:0];
    quo_o   = {quo_i[DATA_W-2:0], fits};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 2-cycle multiply, 34-cycle restoring divide.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  import muldiv_unit_pkg::*;

  mdu_state_e        state_q, state_d;
  mdu_ctrl_t         ctrl_q, ctrl_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic [DATA_W-1:0] rem_step, quo_step;
  logic [PROD_W-1:0] mul_a, mul_b, prod;
  logic [DATA_W-1:0] fix_quo, fix_rem;
  logic              op_signed_div;
  logic              op_is_rem;

  muldiv_unit_div_iter u_div_iter (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (b_q),
    .rem_o (rem_step),
    .quo_o (quo_step)
  );

  // Multiplier (multiplicand kept in quo_q) and divide sign fix-up
  always_comb begin
    mul_a     = {{DATA_W{((ctrl_q.op == ALUOP_MULH) || (ctrl_q.op == ALUOP_MULHSU)) & quo_q[DATA_W-1]}}, quo_q};
    mul_b     = {{DATA_W{(ctrl_q.op == ALUOP_MULH) & b_q[DATA_W-1]}}, b_q};
    prod      = mul_a * mul_b;
    fix_quo   = ctrl_q.neg_quo ? DATA_W'(-quo_q) : quo_q;
    fix_rem   = ctrl_q.neg_rem ? DATA_W'(-rem_q) : rem_q;
    op_is_rem = (ctrl_q.op == ALUOP_REM) || (ctrl_q.op == ALUOP_REMU);
  end

  assign op_signed_div = (op_i == ALUOP_DIV) || (op_i == ALUOP_REM);

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      MDU_IDLE: begin
        if (start_i && !kill_i && is_m_op(op_i)) begin
          ctrl_d.op      = op_i;
          ctrl_d.neg_quo = 1'b0;
          ctrl_d.neg_rem = 1'b0;
          if (is_mul_op(op_i)) begin
            quo_d   = rs1_i;
            b_d     = rs2_i;
            state_d = MDU_MUL;
          end else if (rs2_i == '0) begin
            // Divide by zero: all-ones quotient, dividend as remainder
            quo_d   = '1;
            rem_d   = rs1_i;
            state_d = MDU_FIX;
          end else if (op_signed_div && (rs1_i == 32'h8000_0000) && (rs2_i == '1)) begin
            quo_d   = 32'h8000_0000;
            rem_d   = '0;
            state_d = MDU_FIX;
          end else begin
            ctrl_d.neg_quo = op_signed_div & (rs1_i[DATA_W-1] ^ rs2_i[DATA_W-1]);
            ctrl_d.neg_rem = op_signed_div & rs1_i[DATA_W-1];
            quo_d   = op_signed_div ? abs_w(rs1_i) : rs1_i;
            b_d     = op_signed_div ? abs_w(rs2_i) : rs2_i;
            rem_d   = '0;
            cnt_d   = CNT_W'(31);
            state_d = MDU_DIV;
          end
        end
      end
      MDU_MUL: begin
        result_d = (ctrl_q.op == ALUOP_MUL) ? prod[DATA_W-1:0] : prod[PROD_W-1:DATA_W];
        state_d  = MDU_DONE;
      end
      MDU_DIV: begin
        rem_d = rem_step;
        quo_d = quo_step;
        if (cnt_q == '0) begin
          state_d = MDU_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MDU_FIX: begin
        result_d = op_is_rem ? fix_rem : fix_quo;
        state_d  = MDU_DONE;
      end
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
    // Flush aborts without touching the visible result
    if (kill_i) begin
      state_d  = MDU_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MDU_IDLE;
      ctrl_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != MDU_IDLE);
  assign done_o   = (state_q == MDU_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver queues expected results, monitor checks on done_o.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        kill = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  logic [31:0] exp_res_q[$];
  int unsigned exp_cyc_q[$];
  string       exp_name_q[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .rs1_i   (rs1),
    .rs2_i   (rs2),
    .kill_i  (kill),
    .busy_o  (busy),
    .done_o  (done),
    .result_o(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result 0x%08h expected no done", result);
      end else begin
        string       nm;
        logic [31:0] er;
        int unsigned ec;
        nm = exp_name_q.pop_front();
        er = exp_res_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk({nm, "_result"}, result, er);
        chk({nm, "_latency"}, cyc, ec);
      end
    end
  end

  task automatic push_exp(input string name, input logic [31:0] res, input int unsigned lat);
    exp_name_q.push_back(name);
    exp_res_q.push_back(res);
    exp_cyc_q.push_back(cyc + lat - 1);
  endtask

  // Issue one op, queue its expectation, and measure how long busy stays high
  task automatic run_op(input string name, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int unsigned lat);
    int unsigned n;
    @(negedge clk);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    push_exp(name, exp, lat);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk({name, "_busy_len"}, n, lat);
    chk({name, "_done_seen"}, exp_res_q.size(), 0);
    exp_res_q.delete(); exp_cyc_q.delete(); exp_name_q.delete();
  endtask

  task automatic launch_unchecked(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prev;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;

    run_op("mul_7x_m3",      ALUOP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    run_op("mulh_min_min",   ALUOP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2);
    run_op("mulhu_ones",     ALUOP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("mulhsu_ones",    ALUOP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_op("div_m7_2",       ALUOP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",       ALUOP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
    run_op("divu_100_7",     ALUOP_DIVU,   32'd100,        32'd7,         32'd14,        34);
    run_op("remu_100_7",     ALUOP_REMU,   32'd100,        32'd7,         32'd2,         34);
    run_op("divu_max_1",     ALUOP_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34);
    run_op("divu_5_0",       ALUOP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 2);
    run_op("remu_5_0",       ALUOP_REMU,   32'd5,          32'd0,         32'd5,         2);
    run_op("div_ovf",        ALUOP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("rem_ovf",        ALUOP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2);
    run_op("div_20_m3",      ALUOP_DIV,    32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 34);
    run_op("rem_20_m3",      ALUOP_REM,    32'd20,         32'hFFFF_FFFD, 32'd2,         34);

    // Kill 10 cycles into a divide: no done, result untouched
    prev = 32'd2;
    launch_unchecked(ALUOP_DIVU, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_done", 32'(done), 32'd0);
    chk("kill_result", result, prev);
    repeat (40) @(negedge clk);
    run_op("mul_3x4", ALUOP_MUL, 32'd3, 32'd4, 32'd12, 2);

    // Kill and start together in IDLE: kill wins
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = ALUOP_DIVU; rs1 = 32'd9; rs2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    @(negedge clk);
    chk("kill_start_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    // Reset in the middle of a divide
    launch_unchecked(ALUOP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    rst = 1'b0;
    run_op("mul_after_rst", ALUOP_MUL, 32'd6, 32'd7, 32'd42, 2);

    // start held through a MUL's DONE: exactly one more accept, in the following IDLE
    @(negedge clk);
    start = 1'b1; op = ALUOP_MUL; rs1 = 32'd5; rs2 = 32'd6;
    @(posedge clk); #1;
    push_exp("hold_first", 32'd30, 2);
    rs1 = 32'd7;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("hold_idle_gap_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    push_exp("hold_second", 32'd42, 2);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("hold_done_seen", exp_res_q.size(), 0);
    chk("hold_end_busy", 32'(busy), 32'd0);
    exp_res_q.delete(); exp_cyc_q.delete(); exp_name_q.delete();

    // Non-M op is ignored
    @(negedge clk);
    start = 1'b1; op = ALUOP_ADD; rs1 = 32'd1; rs2 = 32'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("add_busy", 32'(busy), 32'd0);
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("add_result_kept", result, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
